// File: rtl/vpu_wb_pkg.sv
// Shared definitions for the VPU write-back collector: lane width, FSM state
// encodings and the FIFO entry width helper.
package vpu_wb_pkg;

  localparam int LANE_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // One entry holds {address, P data lanes, P nonzero flags}.
  function automatic int fifo_entry_w(input int aw, input int p);
    return aw + p * (LANE_W + 1);
  endfunction

endpackage

// File: rtl/vpu_wb_fifo.sv
// Show-ahead synchronous FIFO with asynchronous reset: head always shows the
// oldest entry, and push/pop may coincide even when full.
module vpu_wb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          empty, full, do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push = push_i & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_push && !do_pop) cnt_d = cnt_q + CW'(1);
    if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = empty;
  assign count_o = cnt_q;

endmodule

// File: rtl/vpu_wb_collector.sv
// Write-back collector: tags issued VPU ops, captures results VPU_LAT cycles later,
// buffers them and drains to memory with an auto-incrementing address. Option: ZERO_SKIP_EN.
module vpu_wb_collector
  import vpu_wb_pkg::*;
#(
  parameter int P       = 64,
  parameter int VPU_LAT = 1,
  parameter int DEPTH   = 4,
  parameter int AW      = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [AW-1:0]       base_addr,
  input  logic                iss_valid,
  input  logic                iss_last,
  output logic                iss_ready,
  input  logic [P*LANE_W-1:0] vpu_rslt,
  input  logic [P-1:0]        vpu_nonz,
  output logic                wr_valid,
  input  logic                wr_ready,
  output logic [AW-1:0]       wr_addr,
  output logic [P*LANE_W-1:0] wr_data,
  output logic [P-1:0]        wr_nonz,
  output logic                busy,
  output logic                done,
  output logic [AW-1:0]       skip_cnt,
  output logic [1:0]          state_dbg
);

  localparam int EW = fifo_entry_w(AW, P);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = CW + 1;

  // Handshakes: an issue transfers when iss_valid & iss_ready, a write when
  // wr_valid & wr_ready; wr_* hold steady while wr_valid is high and not accepted.

  logic [1:0]         state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [VPU_LAT-1:0] tag_q, tag_d;
  logic               iss_acc, capture, push, pop, fifo_empty, tag_any, drain_clear;
  logic [CW-1:0]      fifo_count, inflight;
  logic [OW-1:0]      occupancy;
  logic [P-1:0]       nonz_rev;
  logic [EW-1:0]      push_entry, head;

  always_comb begin
    inflight = '0;
    for (int k = 0; k < VPU_LAT; k++) inflight = inflight + CW'(tag_q[k]);
  end

  // Buffered plus in-flight never exceeds DEPTH, so every result has a slot.
  assign occupancy = OW'(fifo_count) + OW'(inflight);
  assign iss_ready = (state_q == ST_RUN) && (occupancy < OW'(DEPTH));
  assign iss_acc   = iss_valid & iss_ready;
  assign tag_any   = |tag_q;
  assign capture   = tag_q[VPU_LAT-1];

  always_comb begin
    tag_d    = '0;
    tag_d[0] = iss_acc;
    for (int k = 1; k < VPU_LAT; k++) tag_d[k] = tag_q[k-1];
  end

  always_comb begin
    nonz_rev = '0;
    for (int i = 0; i < P; i++) nonz_rev[i] = vpu_nonz[P-1-i];
  end

  assign push_entry  = {addr_q, vpu_rslt, nonz_rev};
  assign wr_valid    = ~fifo_empty;
  assign pop         = wr_valid & wr_ready;
  // The job is finished once this cycle's write empties the pipeline.
  assign drain_clear = ~tag_any & (fifo_empty | ((fifo_count == CW'(1)) & pop));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (iss_acc && iss_last) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_clear) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    if (state_q == ST_IDLE && start) addr_d = base_addr;
    else if (capture)                addr_d = addr_q + AW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tag_q   <= tag_d;
    end
  end

`ifdef ZERO_SKIP_EN
  logic [AW-1:0] skip_q, skip_d;
  logic          cap_zero;

  // An all-zero vector keeps its address slot but is never written.
  assign cap_zero = ~|vpu_nonz;
  assign push     = capture & ~cap_zero;

  always_comb begin
    skip_d = skip_q;
    if (state_q == ST_IDLE && start) skip_d = '0;
    else if (capture && cap_zero)    skip_d = skip_q + AW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) skip_q <= '0;
    else     skip_q <= skip_d;
  end

  assign skip_cnt = skip_q;
`else
  assign push     = capture;
  assign skip_cnt = '0;
`endif

  vpu_wb_fifo #(
    .W     (EW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign wr_addr   = head[EW-1 -: AW];
  assign wr_data   = head[EW-AW-1 -: P*LANE_W];
  assign wr_nonz   = head[P-1:0];
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_vpu_wb_collector.sv
// Randomized bench for vpu_wb_collector: a queue-based model of issues, captures,
// writes and job completion is compared cycle by cycle against the design.
module tb_vpu_wb_collector;
  import vpu_wb_pkg::*;

  localparam int P         = 64;
  localparam int LAT       = 1;
  localparam int DEPTH     = 4;
  localparam int AW        = 12;
  localparam int DW        = P * 8;
  localparam int EW        = AW + DW + P;
  localparam int JOB_BOUND = 400;
`ifdef ZERO_SKIP_EN
  localparam bit SKIP_ON = 1'b1;
`else
  localparam bit SKIP_ON = 1'b0;
`endif

  logic          clk, rst, start;
  logic [AW-1:0] base_addr;
  logic          iss_valid, iss_last, iss_ready;
  logic [DW-1:0] vpu_rslt;
  logic [P-1:0]  vpu_nonz;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [P-1:0]  wr_nonz;
  logic          busy, done;
  logic [AW-1:0] skip_cnt;
  logic [1:0]    state_dbg;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] job_data [64];
  logic [P-1:0]  job_nonz [64];
  int            pend_due [$];
  logic [DW-1:0] pend_dat [$];
  logic [P-1:0]  pend_nz  [$];
  logic [EW-1:0] exp_q    [$];
  int            exp_cyc_q[$];

  vpu_wb_collector #(.P(P), .VPU_LAT(LAT), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .iss_valid (iss_valid),
    .iss_last  (iss_last),
    .iss_ready (iss_ready),
    .vpu_rslt  (vpu_rslt),
    .vpu_nonz  (vpu_nonz),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_nonz   (wr_nonz),
    .busy      (busy),
    .done      (done),
    .skip_cnt  (skip_cnt),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [P-1:0] rev(input logic [P-1:0] v);
    logic [P-1:0] r;
    for (int i = 0; i < P; i++) r[i] = v[P-1-i];
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [P-1:0] rand_nonz();
    logic [P-1:0] v;
    v = {$urandom(), $urandom()};
    if (v == '0) v = 1;
    return v;
  endfunction

  function automatic bit is_skip(input logic [P-1:0] nz);
    return SKIP_ON && (nz == '0);
  endfunction

  task automatic fill_job(input int n, input int zero_pct);
    for (int i = 0; i < n; i++) begin
      job_data[i] = rand_data();
      job_nonz[i] = ($urandom_range(1, 100) <= zero_pct) ? '0 : rand_nonz();
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0; iss_valid = 1'b0; iss_last = 1'b0;
  endtask

  // Driver + scoreboard for one job. rdy_mode: 0 always ready, 1 random, 2 stalled for 'stall' cycles.
  task automatic run_job(input logic [AW-1:0] base, input int n, input int rdy_mode,
                         input int stall, input int dens);
    int            issued = 0, outstanding = 0, last_cyc = 0, skips = 0;
    bit            last_acc = 0, drain_ok = 0, finished = 0;
    bit            exp_done, exp_valid, exp_rdy, real_iss;
    int            rel_q[$];
    logic [EW-1:0] head;
    logic [AW-1:0] ea;
    pend_due.delete(); pend_dat.delete(); pend_nz.delete();
    exp_q.delete(); exp_cyc_q.delete();
    for (int jc = 0; jc < JOB_BOUND && !finished; jc++) begin
      @(negedge clk);
      if (pend_due.size() > 0 && pend_due[0] == jc) begin
        vpu_rslt = pend_dat.pop_front();
        vpu_nonz = pend_nz.pop_front();
        void'(pend_due.pop_front());
      end else begin
        vpu_rslt = rand_data();
        vpu_nonz = {$urandom(), $urandom()};
      end
      start     = (jc == 0) || ($urandom_range(0, 7) == 0);
      base_addr = (jc == 0) ? base : AW'($urandom());
      real_iss  = (jc > 0) && !last_acc && (issued < n) && ($urandom_range(1, 100) <= dens);
      if (real_iss) begin
        iss_valid = 1'b1;
        iss_last  = (issued == n - 1);
      end else begin
        iss_valid = ((jc == 0) || last_acc) && ($urandom_range(0, 3) == 0);
        iss_last  = 1'($urandom_range(0, 1));
      end
      case (rdy_mode)
        0:       wr_ready = 1'b1;
        1:       wr_ready = 1'($urandom_range(0, 1));
        default: wr_ready = (jc > stall);
      endcase
      #1;
      exp_done = drain_ok;
      check_val("done", done, exp_done);
      check_val("busy", busy, jc > 0);
      exp_rdy = (jc > 0) && !last_acc && (outstanding < DEPTH);
      check_val("iss_ready", iss_ready, exp_rdy);
      exp_valid = (exp_q.size() > 0) && (exp_cyc_q[0] + LAT + 1 <= jc);
      check_val("wr_valid", wr_valid, exp_valid);
      if (wr_valid && exp_valid) begin
        head = exp_q[0];
        check_val("wr_addr", wr_addr, head[EW-1 -: AW]);
        check_val("wr_data", wr_data, head[DW+P-1 -: DW]);
        check_val("wr_nonz", wr_nonz, head[P-1:0]);
        if (wr_ready) begin
          void'(exp_q.pop_front());
          void'(exp_cyc_q.pop_front());
          outstanding--;
        end
      end
      if (iss_valid && iss_ready && real_iss) begin
        pend_due.push_back(jc + LAT);
        pend_dat.push_back(job_data[issued]);
        pend_nz.push_back(job_nonz[issued]);
        ea = base + AW'(issued);
        if (is_skip(job_nonz[issued])) begin
          rel_q.push_back(jc + LAT);
          skips++;
        end else begin
          exp_q.push_back({ea, job_data[issued], rev(job_nonz[issued])});
          exp_cyc_q.push_back(jc);
        end
        outstanding++;
        if (iss_last) begin
          last_acc = 1'b1;
          last_cyc = jc;
        end
        issued++;
      end
      while (rel_q.size() > 0 && rel_q[0] == jc) begin
        void'(rel_q.pop_front());
        outstanding--;
      end
      if (exp_done) begin
        check_val("skip_cnt", skip_cnt, SKIP_ON ? DW'(skips) : '0);
        finished = 1'b1;
      end
      drain_ok = last_acc && (jc >= last_cyc + LAT + 1) && (exp_q.size() == 0) && !exp_done;
    end
    if (!finished) check_val("job_timeout", 0, 1);
    idle_inputs();
  endtask

  task automatic reset_mid_drain();
    @(negedge clk);
    start = 1'b1; base_addr = 12'h100; wr_ready = 1'b0; iss_valid = 1'b0; iss_last = 1'b0;
    @(negedge clk);
    start = 1'b0; iss_valid = 1'b1; iss_last = 1'b0;
    #1 check_val("rst_seq_rdy0", iss_ready, 1);
    @(negedge clk);
    iss_last = 1'b1; vpu_rslt = rand_data(); vpu_nonz = 64'h1;
    #1 check_val("rst_seq_rdy1", iss_ready, 1);
    @(negedge clk);
    iss_valid = 1'b0; iss_last = 1'b0; vpu_rslt = rand_data(); vpu_nonz = 64'h2;
    @(negedge clk);
    #1 check_val("rst_seq_wr_valid", wr_valid, 1);
    check_val("rst_seq_busy", busy, 1);
    check_val("rst_seq_state", state_dbg, ST_DRAIN);
    rst = 1'b1;
    #1 check_val("midrst_wr_valid", wr_valid, 0);
    check_val("midrst_busy", busy, 0);
    check_val("midrst_done", done, 0);
    check_val("midrst_wr_addr", wr_addr, 0);
    check_val("midrst_wr_data", wr_data, 0);
    check_val("midrst_wr_nonz", wr_nonz, 0);
    @(negedge clk);
    rst = 1'b0; wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 check_val("postrst_wr_valid", wr_valid, 0);
      check_val("postrst_done", done, 0);
      check_val("postrst_busy", busy, 0);
    end
  endtask

  initial begin
    rst = 1'b1; base_addr = '0; wr_ready = 1'b0;
    vpu_rslt = '0; vpu_nonz = '0;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_wr_valid", wr_valid, 0);
    check_val("rst_iss_ready", iss_ready, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_skip_cnt", skip_cnt, 0);
    check_val("rst_wr_addr", wr_addr, 0);
    check_val("rst_wr_data", wr_data, 0);
    check_val("rst_wr_nonz", wr_nonz, 0);
    check_val("rst_state", state_dbg, ST_IDLE);
    @(negedge clk);
    rst = 1'b0;

    // single vector, lane0 = 0x7F
    fill_job(1, 0);
    job_data[0][7:0] = 8'h7F;
    run_job(12'h010, 1, 0, 0, 100);

    // 8-vector stream at full rate
    fill_job(8, 0);
    run_job(12'h010, 8, 0, 0, 100);

    // backpressure: memory stalled for 10 cycles
    fill_job(6, 0);
    run_job(12'h020, 6, 2, 10, 100);

    // address wrap
    fill_job(4, 0);
    run_job(12'hFFE, 4, 0, 0, 100);

    // nonzero flag ordering
    fill_job(2, 0);
    job_nonz[0] = 64'h8000_0000_0000_0001;
    job_nonz[1] = 64'h0000_0000_0000_0001;
    run_job(12'h040, 2, 0, 0, 100);

    // all-zero vector in slot 2 of 4
    fill_job(4, 0);
    job_nonz[2] = '0;
    run_job(12'h010, 4, 0, 0, 100);

    reset_mid_drain();
    fill_job(3, 0);
    run_job(12'h200, 3, 0, 0, 100);

    for (int j = 0; j < 8; j++) begin
      int n;
      n = $urandom_range(1, 20);
      fill_job(n, 20);
      run_job(AW'($urandom()), n, $urandom_range(0, 2), $urandom_range(0, 12), $urandom_range(30, 100));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
